// File: rtl/loong_pkg.sv
// Shared LOONG definitions: nibble type, S-box, FSM states and the
// round-constant / key-update helpers used by the key schedule.
package loong_pkg;

    localparam int NIBBLES     = 16;   // nibbles per round key
    localparam int KEY_NIBBLES = 32;   // nibbles in the master key register

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0] RC_INIT = 6'h01;

    localparam nibble_t LOONG_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // 6-bit round-constant LFSR step: shift left, feed back rc5 ^ rc4 ^ 1.
    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // Key register update between rounds: rotate left by one byte, then
    // substitute the top nibble (the one that ends up there after the rotate).
    function automatic logic [KEY_NIBBLES*4-1:0] key_step(input logic [KEY_NIBBLES*4-1:0] k);
        logic [KEY_NIBBLES*4-1:0] r;
        r = {k[KEY_NIBBLES*4-9:0], k[KEY_NIBBLES*4-1 -: 8]};
        r[KEY_NIBBLES*4-1 -: 4] = LOONG_SBOX[r[KEY_NIBBLES*4-1 -: 4]];
        return r;
    endfunction

    // Round key = low 16 nibbles of the key register with the constant
    // folded into nibbles 0 and 1.
    function automatic logic [NIBBLES*4-1:0] round_key_of(input logic [KEY_NIBBLES*4-1:0] k,
                                                          input logic [5:0] rc);
        logic [NIBBLES*4-1:0] r;
        r      = k[NIBBLES*4-1:0];
        r[3:0] = r[3:0] ^ rc[3:0];
        r[7:4] = r[7:4] ^ {2'b00, rc[5:4]};
        return r;
    endfunction

endpackage

// File: rtl/loong_rc_lfsr.sv
// Round-constant generator for the key schedule. rc_d is the value the
// register takes at the next edge, so the schedule can register a round key
// that already includes the constant for the key it is about to present.
module loong_rc_lfsr
    import loong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    output logic [5:0] rc_d
);

    logic [5:0] rc_q;

    // Next constant: reload on a new run, advance on each consumed key.
    always_comb begin
        rc_d = rc_q;
        if (load)
            rc_d = RC_INIT;
        else if (step)
            rc_d = rc_next(rc_q);
    end

    // Constant register, back to the initial value on reset.
    always_ff @(posedge clk) begin
        if (reset)
            rc_q <= RC_INIT;
        else
            rc_q <= rc_d;
    end

endmodule

// File: rtl/loong_key_schedule.sv
// LOONG key schedule: latches a 128-bit master key on start and streams
// ROUNDS+1 round keys (index 0 = whitening key) over a valid/ready handshake.
// All outputs come straight from registers, so rk_ready never reaches
// round_key combinationally.
module loong_key_schedule
    import loong_pkg::*;
#(
    parameter  int ROUNDS = 16,
    localparam int IDXW   = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0][31:0]  master_key,
    input  logic              rk_ready,
    output logic [3:0][15:0]  round_key,
    output logic              rk_valid,
    output logic [IDXW-1:0]   round_idx,
    output logic              busy,
    output logic              done
);

    state_e                       state, state_nxt;
    logic [KEY_NIBBLES*4-1:0]     key_reg, key_nxt;
    logic [5:0]                   rc_d;
    logic                         accept;   // start taken in IDLE
    logic                         xfer;     // key handed to the encryptor
    logic                         last;     // that key was index ROUNDS
    logic                         advance;  // move on to the next key

    assign accept  = (state == IDLE) && start;
    assign xfer    = (state == RUN) && rk_valid && rk_ready;
    assign last    = xfer && (round_idx == IDXW'(ROUNDS));
    assign advance = xfer && !last;

    loong_rc_lfsr u_rc (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (advance),
        .rc_d  (rc_d)
    );

    // Run control: one pass through RUN per accepted start, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Key register contents for the next cycle: latch or expand one round.
    always_comb begin
        key_nxt = key_reg;
        if (accept)
            key_nxt = master_key;
        else if (advance)
            key_nxt = key_step(key_reg);
    end

    // Key register.
    always_ff @(posedge clk) begin
        if (reset)
            key_reg <= '0;
        else
            key_reg <= key_nxt;
    end

    // Output stage: present the key for the next index, hold while stalled,
    // clear once the final key has been taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_key <= '0;
            rk_valid  <= 1'b0;
            round_idx <= '0;
        end else if (accept) begin
            round_key <= round_key_of(key_nxt, rc_d);
            rk_valid  <= 1'b1;
            round_idx <= '0;
        end else if (last) begin
            round_key <= '0;
            rk_valid  <= 1'b0;
            round_idx <= '0;
        end else if (advance) begin
            round_key <= round_key_of(key_nxt, rc_d);
            round_idx <= round_idx + 1'b1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_loong_key_schedule.sv
// Bench for loong_key_schedule: a ROUNDS=16 and a ROUNDS=4 instance, each
// compared against a nibble-array model of the key expansion.
module tb_loong_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start16, start4, ready16, ready4;
    logic [3:0][31:0] mk16, mk4;
    logic [3:0][15:0] rk16, rk4;
    logic             v16, v4, busy16, busy4, done16, done4;
    logic [4:0]       idx16;
    logic [2:0]       idx4;

    int npass = 0;
    int ntot  = 0;

    logic [63:0] exp_k  [0:16];
    int          exp_rc [0:16];
    int          SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    loong_key_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .master_key(mk16), .rk_ready(ready16),
        .round_key(rk16), .rk_valid(v16), .round_idx(idx16), .busy(busy16), .done(done16)
    );

    loong_key_schedule #(.ROUNDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .master_key(mk4), .rk_ready(ready4),
        .round_key(rk4), .rk_valid(v4), .round_idx(idx4), .busy(busy4), .done(done4)
    );

    // Reference: key as 32 nibbles, rotate by two nibble positions, S-box on
    // the top nibble, constant as an integer sequence.
    task automatic build_model(input logic [127:0] mk, input int rounds);
        int nib [32];
        int tmp [32];
        int rc;
        logic [63:0] k;
        for (int j = 0; j < 32; j++) nib[j] = int'(mk[4*j +: 4]);
        rc = 1;
        for (int i = 0; i <= rounds; i++) begin
            k = '0;
            for (int j = 0; j < 16; j++) k[4*j +: 4] = 4'(nib[j]);
            k[3:0] = k[3:0] ^ 4'(rc % 16);
            k[7:4] = k[7:4] ^ 4'(rc / 16);
            exp_k[i]  = k;
            exp_rc[i] = rc;
            for (int j = 0; j < 32; j++) tmp[(j + 2) % 32] = nib[j];
            for (int j = 0; j < 32; j++) nib[j] = tmp[j];
            nib[31] = SB[nib[31]];
            rc = (rc * 2) % 64 + ((rc / 32 + (rc / 16) % 2 + 1) % 2);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start16 = 0; start4 = 0; ready16 = 0; ready4 = 0; mk16 = '0; mk4 = '0;
        repeat (3) @(negedge clk);
        ntot++; if (rk16 !== 64'h0) $display("FAIL reset_key got %h want 0", rk16); else npass++;
        ntot++; if ({v16, busy16, done16} !== 3'b000) $display("FAIL reset_flags got %b want 000", {v16, busy16, done16}); else npass++;
        ntot++; if (idx16 !== 5'd0) $display("FAIL reset_idx got %0d want 0", idx16); else npass++;
        ntot++; if ({v4, busy4, done4, idx4} !== 6'b0 || rk4 !== 64'h0) $display("FAIL reset_dut4 got %b/%h want 0", {v4, busy4, done4, idx4}, rk4); else npass++;
        reset = 1'b0;
        @(negedge clk);
        ntot++; if (v16 !== 1'b0) $display("FAIL idle_no_valid got %b want 0", v16); else npass++;
    endtask

    task automatic test_zero_key();
        logic [3:0] n0 [3];
        logic [63:0] k;
        n0 = '{4'h1, 4'h3, 4'h7};
        build_model('0, 16);
        mk16 = '0; ready16 = 1; start16 = 1;
        @(negedge clk); start16 = 0;
        for (int i = 0; i <= 16; i++) begin
            k = rk16;
            ntot++; if (v16 !== 1'b1 || int'(idx16) != i) $display("FAIL zero_stream i=%0d got v=%b idx=%0d want v=1 idx=%0d", i, v16, idx16, i); else npass++;
            ntot++; if (k !== exp_k[i]) $display("FAIL zero_key i=%0d got %h want %h", i, k, exp_k[i]); else npass++;
            if (i < 3) begin
                ntot++; if (k[3:0] !== n0[i] || k[63:8] !== 56'h0) $display("FAIL zero_nibbles i=%0d got %h want nib0=%h upper 0", i, k, n0[i]); else npass++;
            end
            @(negedge clk);
        end
        ntot++; if (done16 !== 1'b1 || v16 !== 1'b0) $display("FAIL zero_done got done=%b v=%b want 1/0", done16, v16); else npass++;
        @(negedge clk);
        ntot++; if (done16 !== 1'b0 || busy16 !== 1'b0) $display("FAIL zero_done_pulse got done=%b busy=%b want 0/0", done16, busy16); else npass++;
    endtask

    // With an all-zero master key the even nibbles stay zero, so nib0 is the constant's low nibble.
    task automatic test_rc_trace();
        logic [3:0] lit [8];
        logic [63:0] k;
        lit = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hE, 4'hD, 4'hB};
        build_model('0, 16);
        mk16 = '0; ready16 = 1; start16 = 1;
        @(negedge clk); start16 = 0;
        for (int i = 0; i <= 16; i++) begin
            k = rk16;
            if (i < 8) begin
                ntot++; if (k[3:0] !== lit[i]) $display("FAIL rc_trace i=%0d got %h want %h", i, k[3:0], lit[i]); else npass++;
            end
            ntot++; if (int'(k[3:0]) != exp_rc[i] % 16) $display("FAIL rc_model i=%0d got %h want %h", i, k[3:0], exp_rc[i] % 16); else npass++;
            @(negedge clk);
        end
        ntot++; if (done16 !== 1'b1) $display("FAIL rc_done got %b want 1", done16); else npass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [127:0] mk;
        mk = rand128(); build_model(mk, 16);
        mk16 = mk; ready16 = 1; start16 = 1;
        @(negedge clk); start16 = 0;
        repeat (3) @(negedge clk);
        ntot++; if (idx16 !== 5'd3 || rk16 !== exp_k[3]) $display("FAIL stall_pre got idx=%0d key=%h want 3/%h", idx16, rk16, exp_k[3]); else npass++;
        ready16 = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ntot++; if (rk16 !== exp_k[3] || idx16 !== 5'd3 || v16 !== 1'b1) $display("FAIL stall_hold c=%0d got idx=%0d key=%h v=%b want 3/%h/1", c, idx16, rk16, v16, exp_k[3]); else npass++;
        end
        ready16 = 1;
        @(negedge clk);
        ntot++; if (idx16 !== 5'd4 || rk16 !== exp_k[4]) $display("FAIL stall_resume got idx=%0d key=%h want 4/%h", idx16, rk16, exp_k[4]); else npass++;
        for (int n = 0; n < 40 && !done16; n++) @(negedge clk);
        ntot++; if (done16 !== 1'b1) $display("FAIL stall_drain got done=%b want 1", done16); else npass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] mk;
        mk16 = rand128(); ready16 = 1; start16 = 1;
        @(negedge clk); start16 = 0;
        repeat (7) @(negedge clk);
        ntot++; if (idx16 !== 5'd7) $display("FAIL rst_mid_pre got idx=%0d want 7", idx16); else npass++;
        reset = 1;
        @(negedge clk);
        ntot++; if (rk16 !== 64'h0 || {v16, busy16, done16} !== 3'b000 || idx16 !== 5'd0) $display("FAIL rst_mid got key=%h flags=%b idx=%0d want 0", rk16, {v16, busy16, done16}, idx16); else npass++;
        reset = 0;
        mk = rand128(); build_model(mk, 16);
        mk16 = mk; start16 = 1;
        @(negedge clk); start16 = 0;
        ntot++; if (v16 !== 1'b1 || idx16 !== 5'd0 || rk16 !== exp_k[0]) $display("FAIL rst_restart got v=%b idx=%0d key=%h want 1/0/%h", v16, idx16, rk16, exp_k[0]); else npass++;
        for (int n = 0; n < 40 && !done16; n++) @(negedge clk);
        ntot++; if (done16 !== 1'b1) $display("FAIL rst_drain got done=%b want 1", done16); else npass++;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        build_model('0, 16);
        mk16 = '0; ready16 = 1; start16 = 1;
        @(negedge clk); start16 = 0;
        for (int i = 0; i <= 16; i++) begin
            ntot++; if (rk16 !== exp_k[i] || int'(idx16) != i) $display("FAIL ign_key i=%0d got idx=%0d key=%h want %h", i, idx16, rk16, exp_k[i]); else npass++;
            start16 = (i == 5);
            if (i == 5) mk16 = rand128();
            @(negedge clk);
        end
        ntot++; if (done16 !== 1'b1) $display("FAIL ign_done got %b want 1", done16); else npass++;
        start16 = 1;
        @(negedge clk); start16 = 0;
        ntot++; if ({v16, busy16, done16} !== 3'b000) $display("FAIL ign_done_start got flags=%b want 000", {v16, busy16, done16}); else npass++;
        @(negedge clk);
        ntot++; if (v16 !== 1'b0 || busy16 !== 1'b0) $display("FAIL ign_no_restart got v=%b busy=%b want 0/0", v16, busy16); else npass++;
    endtask

    task automatic test_random();
        logic [127:0] mk;
        logic [63:0] k;
        logic v, d, r;
        int R, ix, expi, xfers;
        bit seen_done;
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < 2; w++) begin
                R = (w == 1) ? 4 : 16;
                mk = rand128(); build_model(mk, R);
                if (w == 1) begin mk4 = mk; start4 = 1; end else begin mk16 = mk; start16 = 1; end
                @(negedge clk); start4 = 0; start16 = 0;
                expi = 0; xfers = 0; seen_done = 0;
                for (int c = 0; c < 200 && !seen_done; c++) begin
                    v  = (w == 1) ? v4 : v16;
                    d  = (w == 1) ? done4 : done16;
                    k  = (w == 1) ? rk4 : rk16;
                    ix = (w == 1) ? int'(idx4) : int'(idx16);
                    if (d) begin
                        seen_done = 1;
                        ntot++; if (v !== 1'b0) $display("FAIL rnd_done_valid R=%0d got v=%b want 0", R, v); else npass++;
                    end else if (v) begin
                        ntot++; if (ix != expi || k !== exp_k[expi]) $display("FAIL rnd_key R=%0d got idx=%0d key=%h want %0d/%h", R, ix, k, expi, exp_k[expi]); else npass++;
                    end
                    r = ($urandom_range(0, 9) < 7);
                    if (w == 1) ready4 = r; else ready16 = r;
                    if (v && r) begin expi++; xfers++; end
                    if (!seen_done) @(negedge clk);
                end
                ntot++; if (!seen_done || xfers != R + 1) $display("FAIL rnd_count R=%0d got xfers=%0d done=%0d want %0d/1", R, xfers, seen_done, R + 1); else npass++;
                ready4 = 0; ready16 = 0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_rc_trace();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
